// File: rtl/alu_control_seq_pkg.sv
// ============================================================================
// alu_control_seq_pkg
// Function codes, HI/LO store encodings, FSM states and the decode table.
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_control_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MD_RUN   = 2'd1,
    ST_MD_STORE = 2'd2
  } state_t;

  localparam logic [31:0] c_fn_add   = 32'd0;
  localparam logic [31:0] c_fn_or    = 32'd8;
  localparam logic [31:0] c_fn_div   = 32'd9;
  localparam logic [31:0] c_fn_mult  = 32'd10;
  localparam logic [31:0] c_fn_subu  = 32'd11;

  localparam logic [1:0] c_storemd_none = 2'b00;
  localparam logic [1:0] c_storemd_div  = 2'b01;
  localparam logic [1:0] c_storemd_mult = 2'b10;

  typedef struct packed {
    logic [2:0] aluop;
    logic [1:0] condtype;
    logic       orop;
    logic       ovf;
    logic [2:0] srcout;
    logic       legal;
  } dec_t;

  // MULT/DIV are legal but drive no single-cycle controls; the sequencer owns them.
  function automatic dec_t decode_fn(input logic [31:0] code);
    dec_t d;
    d       = '0;
    d.legal = 1'b1;
    case (code)
      c_fn_add: d.srcout = 3'd3;
      32'd1, 32'd2, 32'd4: begin
        d.aluop  = code[2:0];
        d.ovf    = 1'b1;
        d.srcout = 3'd3;
      end
      32'd3, 32'd5, 32'd6: begin
        d.aluop  = code[2:0];
        d.srcout = 3'd3;
      end
      32'd7: begin
        d.aluop  = 3'd7;
        d.srcout = 3'd2;
      end
      c_fn_or: begin
        d.orop   = 1'b1;
        d.srcout = 3'd4;
      end
      c_fn_div, c_fn_mult: d.legal = 1'b1;
      c_fn_subu: begin
        d.aluop  = 3'd1;
        d.srcout = 3'd3;
      end
      32'd12: d.srcout = 3'd1;
      32'd13: d.srcout = 3'd0;
      32'd14, 32'd15, 32'd16, 32'd17: d.condtype = code[1:0] + 2'd2;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_control_seq_md_watchdog.sv
// ============================================================================
// alu_control_seq_md_watchdog
// Saturating MULT/DIV cycle counter; expired flags the last permitted cycle.
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_control_seq_md_watchdog #(
  parameter int MD_TIMEOUT = 40
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int c_cnt_w = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(MD_TIMEOUT - 1);

  logic [c_cnt_w-1:0] r_count;

  // Holding at c_last keeps the counter from ever wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != c_last)) begin
      r_count <= r_count + c_cnt_w'(1);
    end
  end

  assign expired = (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/alu_control_seq.sv
// ============================================================================
// alu_control_seq
// Registered ALU control decoder with MULT/DIV start/done sequencing.
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_control_seq #(
  parameter int CTRL_W     = 5,
  parameter int ALUOP_W    = 3,
  parameter int SRC_W      = 3,
  parameter int DATA_W     = 32,
  parameter int MD_TIMEOUT = 40
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_valid,
  input  logic [CTRL_W-1:0]  controlType,
  input  logic [DATA_W-1:0]  divisor,
  input  logic               md_done,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         condType,
  output logic               orOp,
  output logic               overflowOp,
  output logic [SRC_W-1:0]   SrcOut,
  output logic [1:0]         StoreMD,
  output logic               md_start,
  output logic               md_sel,
  output logic               stall,
  output logic               op_done,
  output logic               div_zero,
  output logic               md_timeout,
  output logic               illegal_op
);

  import alu_control_seq_pkg::*;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [31:0]          w_code;
  dec_t                 w_dec;
  logic [ALUOP_W-1:0]   w_aluop_nxt;
  logic [1:0]           w_cond_nxt;
  logic                 w_orop_nxt;
  logic                 w_ovf_nxt;
  logic [SRC_W-1:0]     w_src_nxt;
  logic                 w_sel_nxt;
  logic [1:0]           w_storemd_nxt;
  logic                 w_start_nxt;
  logic                 w_done_nxt;
  logic                 w_dz_nxt;
  logic                 w_to_nxt;
  logic                 w_ill_nxt;
  logic                 w_wd_clear;
  logic                 w_wd_en;
  logic                 w_wd_expired;

  assign w_code = 32'(controlType);

  alu_control_seq_md_watchdog #(
    .MD_TIMEOUT (MD_TIMEOUT)
  ) u_md_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_wd_clear),
    .enable  (w_wd_en),
    .expired (w_wd_expired)
  );

  always_comb begin
    w_dec         = decode_fn(w_code);
    w_state_nxt   = r_state;
    w_aluop_nxt   = ALUOp;
    w_cond_nxt    = condType;
    w_orop_nxt    = orOp;
    w_ovf_nxt     = overflowOp;
    w_src_nxt     = SrcOut;
    w_sel_nxt     = md_sel;
    w_storemd_nxt = c_storemd_none;
    w_start_nxt   = 1'b0;
    w_done_nxt    = 1'b0;
    w_dz_nxt      = 1'b0;
    w_to_nxt      = 1'b0;
    w_ill_nxt     = 1'b0;
    w_wd_clear    = 1'b1;
    w_wd_en       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (op_valid) begin
          w_aluop_nxt = ALUOP_W'(w_dec.aluop);
          w_cond_nxt  = w_dec.condtype;
          w_orop_nxt  = w_dec.orop;
          w_ovf_nxt   = w_dec.ovf;
          w_src_nxt   = SRC_W'(w_dec.srcout);
          w_sel_nxt   = 1'b0;
          if (!w_dec.legal) begin
            w_ill_nxt  = 1'b1;
            w_done_nxt = 1'b1;
          end else if (w_code == c_fn_div) begin
            if (divisor == '0) begin
              w_dz_nxt   = 1'b1;
              w_done_nxt = 1'b1;
            end else begin
              w_sel_nxt   = 1'b1;
              w_start_nxt = 1'b1;
              w_state_nxt = ST_MD_RUN;
            end
          end else if (w_code == c_fn_mult) begin
            w_start_nxt = 1'b1;
            w_state_nxt = ST_MD_RUN;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      ST_MD_RUN: begin
        w_wd_clear = 1'b0;
        w_wd_en    = 1'b1;
        // md_done takes priority over a watchdog expiry in the same cycle.
        if (md_done) begin
          w_state_nxt   = ST_MD_STORE;
          w_storemd_nxt = md_sel ? c_storemd_div : c_storemd_mult;
          w_done_nxt    = 1'b1;
        end else if (w_wd_expired) begin
          w_state_nxt = ST_IDLE;
          w_to_nxt    = 1'b1;
          w_done_nxt  = 1'b1;
        end
      end
      ST_MD_STORE: w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      ALUOp      <= '0;
      condType   <= '0;
      orOp       <= 1'b0;
      overflowOp <= 1'b0;
      SrcOut     <= '0;
      md_sel     <= 1'b0;
      StoreMD    <= c_storemd_none;
      md_start   <= 1'b0;
      stall      <= 1'b0;
      op_done    <= 1'b0;
      div_zero   <= 1'b0;
      md_timeout <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      ALUOp      <= w_aluop_nxt;
      condType   <= w_cond_nxt;
      orOp       <= w_orop_nxt;
      overflowOp <= w_ovf_nxt;
      SrcOut     <= w_src_nxt;
      md_sel     <= w_sel_nxt;
      StoreMD    <= w_storemd_nxt;
      md_start   <= w_start_nxt;
      stall      <= (w_state_nxt == ST_MD_RUN);
      op_done    <= w_done_nxt;
      div_zero   <= w_dz_nxt;
      md_timeout <= w_to_nxt;
      illegal_op <= w_ill_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_control_seq.sv
// ============================================================================
// tb_alu_control_seq
// Randomised scenario bench for alu_control_seq against a cycle-count model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_control_seq;

  localparam int TB_TIMEOUT = 8;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic [4:0]  controlType;
  logic [31:0] divisor;
  logic        md_done;
  logic [2:0]  ALUOp;
  logic [1:0]  condType;
  logic        orOp;
  logic        overflowOp;
  logic [2:0]  SrcOut;
  logic [1:0]  StoreMD;
  logic        md_start;
  logic        md_sel;
  logic        stall;
  logic        op_done;
  logic        div_zero;
  logic        md_timeout;
  logic        illegal_op;

  logic [18:0] obs;
  logic [18:0] exp;
  int          pass_cnt;
  int          total_cnt;

  alu_control_seq #(
    .CTRL_W     (5),
    .ALUOP_W    (3),
    .SRC_W      (3),
    .DATA_W     (32),
    .MD_TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .op_valid    (op_valid),
    .controlType (controlType),
    .divisor     (divisor),
    .md_done     (md_done),
    .ALUOp       (ALUOp),
    .condType    (condType),
    .orOp        (orOp),
    .overflowOp  (overflowOp),
    .SrcOut      (SrcOut),
    .StoreMD     (StoreMD),
    .md_start    (md_start),
    .md_sel      (md_sel),
    .stall       (stall),
    .op_done     (op_done),
    .div_zero    (div_zero),
    .md_timeout  (md_timeout),
    .illegal_op  (illegal_op)
  );

  assign obs = {ALUOp, condType, orOp, overflowOp, SrcOut, StoreMD,
                md_start, md_sel, stall, op_done, div_zero, md_timeout, illegal_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode: {ALUOp, condType, orOp, overflowOp, SrcOut}
  function automatic logic [9:0] ref_dec(input int code);
    logic [2:0] a;
    logic [1:0] c;
    logic       o;
    logic       v;
    logic [2:0] s;
    a = 3'd0; c = 2'd0; s = 3'd0;
    if (code >= 1 && code <= 7) a = 3'(code);
    if (code == 11) a = 3'd1;
    v = (code == 1) || (code == 2) || (code == 4);
    o = (code == 8);
    if ((code >= 0 && code <= 6) || code == 11) s = 3'd3;
    else if (code == 7) s = 3'd2;
    else if (code == 8) s = 3'd4;
    else if (code == 12) s = 3'd1;
    if (code >= 14 && code <= 17) c = 2'(code - 14);
    return {a, c, o, v, s};
  endfunction

  function automatic logic [18:0] ev(input logic [9:0] dec, input logic [1:0] smd,
                                     input logic st, input logic sel, input logic stl,
                                     input logic dn, input logic dz, input logic to,
                                     input logic il);
    return {dec, smd, st, sel, stl, dn, dz, to, il};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; op_valid = 1'b0; controlType = '0; divisor = '0; md_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (obs !== 19'd0) $display("FAIL reset_state obs=%h exp=%h", obs, 19'd0);
    else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_single();
    int          code;
    logic [9:0]  held;
    logic        ill;
    for (int i = 0; i < 40; i++) begin
      if (i == 0) code = 1;
      else if (i == 1) code = 31;
      else if (i == 2) code = 17;
      else if (i == 3) code = 18;
      else begin
        code = $urandom_range(0, 31);
        if (code == 9 || code == 10) code = 13;
      end
      ill  = (code >= 18);
      held = ill ? 10'd0 : ref_dec(code);
      op_valid = 1'b1; controlType = 5'(code); divisor = $urandom;
      tick();
      exp = ev(held, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ill);
      total_cnt++;
      if (obs !== exp) $display("FAIL single code=%0d obs=%h exp=%h", code, obs, exp);
      else pass_cnt++;
      // Random gap cycles; otherwise the next op follows back-to-back.
      if ($urandom_range(0, 1) == 1) begin
        op_valid = 1'b0; controlType = 5'($urandom);
        tick();
        exp = ev(held, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total_cnt++;
        if (obs !== exp) $display("FAIL single_hold code=%0d obs=%h exp=%h", code, obs, exp);
        else pass_cnt++;
      end
    end
    op_valid = 1'b0;
  endtask

  task automatic test_div_zero();
    for (int i = 0; i < 2; i++) begin
      op_valid = 1'b1; controlType = 5'd9; divisor = 32'd0;
      tick();
      exp = ev(10'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      total_cnt++;
      if (obs !== exp) $display("FAIL div_zero obs=%h exp=%h", obs, exp);
      else pass_cnt++;
    end
    op_valid = 1'b0;
    tick();
    exp = ev(10'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (obs !== exp) $display("FAIL div_zero_after obs=%h exp=%h", obs, exp);
    else pass_cnt++;
  endtask

  task automatic test_md();
    int   code;
    int   at;
    int   k;
    bit   finished;
    logic is_div;
    logic [31:0] dv;
    for (int i = 0; i < 14; i++) begin
      case (i)
        0: begin code = 10; dv = 32'd0; at = 4; end
        1: begin code = 9;  dv = 32'd7; at = 4; end
        2: begin code = 9;  dv = 32'd7; at = 0; end
        3: begin code = 10; dv = 32'd3; at = TB_TIMEOUT; end
        4: begin code = 9;  dv = 32'd1; at = 1; end
        default: begin
          code = $urandom_range(9, 10);
          dv   = $urandom | 32'd1;
          at   = $urandom_range(0, TB_TIMEOUT + 2);
        end
      endcase
      is_div = (code == 9);
      op_valid = 1'b1; controlType = 5'(code); divisor = dv; md_done = 1'b0;
      tick();
      k = 1; finished = 1'b0;
      while (!finished) begin
        exp = ev(10'd0, 2'b00, (k == 1), is_div, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        total_cnt++;
        if (obs !== exp) $display("FAIL md_run code=%0d cyc=%0d obs=%h exp=%h", code, k, obs, exp);
        else pass_cnt++;
        // Stray requests during the run must not be accepted.
        op_valid = 1'($urandom_range(0, 1)); controlType = 5'($urandom); divisor = $urandom;
        md_done = (k == at);
        if (k == at || k == TB_TIMEOUT) finished = 1'b1;
        else k++;
        tick();
      end
      md_done = 1'b0;
      if (at >= 1 && at <= TB_TIMEOUT) begin
        exp = ev(10'd0, is_div ? 2'b01 : 2'b10, 1'b0, is_div, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        total_cnt++;
        if (obs !== exp) $display("FAIL md_store code=%0d at=%0d obs=%h exp=%h", code, at, obs, exp);
        else pass_cnt++;
        op_valid = 1'b1; controlType = 5'($urandom_range(0, 8));
      end else begin
        exp = ev(10'd0, 2'b00, 1'b0, is_div, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        total_cnt++;
        if (obs !== exp) $display("FAIL md_timeout code=%0d obs=%h exp=%h", code, obs, exp);
        else pass_cnt++;
        op_valid = 1'b0;
      end
      tick();
      op_valid = 1'b0;
      exp = ev(10'd0, 2'b00, 1'b0, is_div, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      total_cnt++;
      if (obs !== exp) $display("FAIL md_after code=%0d obs=%h exp=%h", code, obs, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    op_valid = 1'b1; controlType = 5'd10; divisor = 32'd5; md_done = 1'b0;
    tick();
    op_valid = 1'b0;
    repeat (4) tick();
    #2 reset = 1'b1;
    #1;
    total_cnt++;
    if (obs !== 19'd0) $display("FAIL reset_async obs=%h exp=%h", obs, 19'd0);
    else pass_cnt++;
    tick();
    reset = 1'b0; md_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (obs !== 19'd0) $display("FAIL post_reset cyc=%0d obs=%h exp=%h", i, obs, 19'd0);
      else pass_cnt++;
    end
    md_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_single();
    test_div_zero();
    test_md();
    test_reset_mid();
    test_single();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
